multicycle_controller: RTL
==========================

# multicycle_controller

Main control unit for the multicycle MIPS processor. A Moore state machine sequences the shared datapath (PC, instruction and data registers, ALU, register file, unified memory) through fetch, decode, execute, memory and writeback cycles. It drives the enables of the enable-flops (`pcen`, `irwrite`) and every mux select. An embedded ALU decoder produces `alucontrol`.

## Interface
Parameters:
- none; opcode and funct encodings are fixed MIPS values.

Ports:
- `clk` in 1: single system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; forces state to FETCH immediately.
- `op` in 6: instruction opcode (IR[31:26]); valid from the DECODE cycle onward.
- `funct` in 6: function field (IR[5:0]).
- `zero` in 1: ALU zero flag, combinational from the datapath.
- `pcen` out 1: PC flop enable, equal to pcwrite OR (branch AND zero).
- `irwrite` out 1: instruction register enable.
- `memwrite` out 1: memory write strobe.
- `regwrite` out 1: register file write enable.
- `iord` out 1: memory address select, 0 = PC, 1 = ALUOut.
- `memtoreg` out 1: writeback data select, 0 = ALUOut, 1 = Data register.
- `regdst` out 1: destination register select, 0 = rt, 1 = rd.
- `alusrca` out 1: ALU A select, 0 = PC, 1 = A register.
- `alusrcb` out 2: ALU B select, 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- `pcsrc` out 2: next-PC select, 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `alucontrol` out 3: ALU operation.
- `state` out 4: current state, for debug.

## Operation
States and encodings:
- FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11.
- Encodings 12–15 are illegal and go to FETCH on the next edge.

Transitions:
- FETCH→DECODE.
- DECODE dispatches on `op`:
  - lw 100011 or sw 101011 → MEMADR.
  - 000000 → RTYPEEX.
  - beq 000100 → BEQEX.
  - addi 001000 → ADDIEX.
  - j 000010 → JEX.
  - any other opcode → FETCH (executes as a NOP).
- MEMADR → MEMRD for lw, → MEMWR for sw.
- MEMRD→MEMWB.
- RTYPEEX→RTYPEWB.
- ADDIEX→ADDIWB.
- MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX and JEX → FETCH.

Outputs not listed for a state are 0. Internal aluop (00 add, 01 sub, 10 funct) is noted per state.
- FETCH: irwrite=1, pcwrite=1, alusrcb=01, aluop=00.
- DECODE: alusrcb=11, aluop=00.
- MEMADR and ADDIEX: alusrca=1, alusrcb=10, aluop=00.
- MEMRD: iord=1.
- MEMWB: memtoreg=1, regwrite=1.
- MEMWR: iord=1, memwrite=1.
- RTYPEEX: alusrca=1, aluop=10.
- RTYPEWB: regdst=1, regwrite=1.
- BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1.
- ADDIWB: regwrite=1.
- JEX: pcsrc=10, pcwrite=1.

ALU decoder:
- aluop 00 → 010 (add).
- aluop 01 → 110 (sub).
- aluop 10 decodes `funct`:
  - 100000 → 010 (add).
  - 100010 → 110 (sub).
  - 100100 → 000 (and).
  - 100101 → 001 (or).
  - 101010 → 111 (slt).
  - any other funct → 010.

## Timing
- Reset values: state=FETCH, so irwrite=1, pcen=1, alusrcb=01, alucontrol=010, and all other outputs are 0. The datapath flops are held by their own reset, which dominates their enables.
- Reset deasserted mid-instruction: the instruction is abandoned and fetch restarts.
- All outputs except `pcen` are pure state decode. `pcen` is combinational through `zero` in BEQEX only.
- Latency in cycles, counted from FETCH back to FETCH:
  - lw 5.
  - sw 4.
  - R-type 4.
  - addi 4.
  - beq 3.
  - j 3.
  - unsupported opcode 2.
- `op` and `funct` are sampled only in DECODE, MEMADR and RTYPEEX. They must stay stable from the edge after FETCH until the instruction completes; IR is not rewritten until the next FETCH, so this holds.

## Configuration
- `MULTICYCLE_JUMP_EN` defined: opcode 000010 → JEX, and pcsrc=10 is reachable.
- `MULTICYCLE_JUMP_EN` undefined: the JEX state is not compiled. Opcode 000010 is an unsupported opcode (DECODE→FETCH), and `pcsrc` never equals 10.

## Test plan
- Reset asserted mid-MEMRD → `state` is 0 asynchronously; after release the sequence is 0,1,…; irwrite=1 in the first cycle.
- lw (op=100011) → states 0,1,2,3,4; regwrite=1 and memtoreg=1 only in state 4; iord=1 in state 3.
- R-type with funct=101010 → states 0,1,6,7; alucontrol=111 in state 6; regdst=1 and regwrite=1 in state 7.
- beq (op=000100) → states 0,1,8; pcen=1 in state 8 with zero=1, pcen=0 with zero=0; alucontrol=110, pcsrc=01.
- sw then op=111111 → sw: states 0,1,2,5 with memwrite=1 only in state 5; unknown opcode: 0,1,0 with no write strobes.
- j (op=000010) with and without `MULTICYCLE_JUMP_EN` → with: 0,1,11 and pcsrc=10, pcen=1; without: 0,1,0.

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM and ALU decoder for the multicycle MIPS datapath; `MULTICYCLE_JUMP_EN enables the j instruction (JEX state)
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);
  localparam logic [3:0] FETCH   = 4'd0;
  localparam logic [3:0] DECODE  = 4'd1;
  localparam logic [3:0] MEMADR  = 4'd2;
  localparam logic [3:0] MEMRD   = 4'd3;
  localparam logic [3:0] MEMWB   = 4'd4;
  localparam logic [3:0] MEMWR   = 4'd5;
  localparam logic [3:0] RTYPEEX = 4'd6;
  localparam logic [3:0] RTYPEWB = 4'd7;
  localparam logic [3:0] BEQEX   = 4'd8;
  localparam logic [3:0] ADDIEX  = 4'd9;
  localparam logic [3:0] ADDIWB  = 4'd10;
`ifdef MULTICYCLE_JUMP_EN
  localparam logic [3:0] JEX     = 4'd11;
  localparam logic [5:0] OP_J    = 6'b000010;
`endif
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic       w_pcwrite;
  logic       w_branch;
  logic [1:0] w_aluop;
  logic [2:0] w_funct_ctl;

  // state register; reset restarts at FETCH immediately
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= FETCH;
    else       r_state <= w_next;

  // next-state logic; illegal encodings and unsupported opcodes fall back to FETCH
  always_comb begin
    w_next = FETCH;
    case (r_state)
      FETCH:   w_next = DECODE;
      DECODE: begin
        w_next = (op == OP_LW || op == OP_SW) ? MEMADR :
                 (op == OP_R)                 ? RTYPEEX :
                 (op == OP_BEQ)               ? BEQEX :
                 (op == OP_ADDI)              ? ADDIEX : FETCH;
`ifdef MULTICYCLE_JUMP_EN
        if (op == OP_J) w_next = JEX;
`endif
      end
      MEMADR:  w_next = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   w_next = MEMWB;
      RTYPEEX: w_next = RTYPEWB;
      ADDIEX:  w_next = ADDIWB;
      default: w_next = FETCH;
    endcase
  end

  // Moore output decode of the current state
  always_comb begin
    irwrite   = 1'b0;
    memwrite  = 1'b0;
    regwrite  = 1'b0;
    iord      = 1'b0;
    memtoreg  = 1'b0;
    regdst    = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = 2'b00;
    pcsrc     = 2'b00;
    w_pcwrite = 1'b0;
    w_branch  = 1'b0;
    w_aluop   = 2'b00;
    case (r_state)
      FETCH: begin
        irwrite   = 1'b1;
        w_pcwrite = 1'b1;
        alusrcb   = 2'b01;
      end
      DECODE:  alusrcb = 2'b11;
      MEMADR, ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD:   iord = 1'b1;
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        w_aluop = 2'b10;
      end
      RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BEQEX: begin
        alusrca  = 1'b1;
        w_aluop  = 2'b01;
        pcsrc    = 2'b01;
        w_branch = 1'b1;
      end
      ADDIWB:  regwrite = 1'b1;
`ifdef MULTICYCLE_JUMP_EN
      JEX: begin
        pcsrc     = 2'b10;
        w_pcwrite = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // ALU decoder: fixed add/sub for address and branch work, funct-driven for R-type
  always_comb begin
    w_funct_ctl = (funct == 6'b100010) ? 3'b110 :
                  (funct == 6'b100100) ? 3'b000 :
                  (funct == 6'b100101) ? 3'b001 :
                  (funct == 6'b101010) ? 3'b111 : 3'b010;
    alucontrol  = (w_aluop == 2'b00) ? 3'b010 :
                  (w_aluop == 2'b01) ? 3'b110 : w_funct_ctl;
  end

  assign pcen  = w_pcwrite | (w_branch & zero);
  assign state = r_state;
endmodule
